// File: rtl/fft_out_stream_pkg.sv
// Shared FFT defaults and the ping-pong bank state type.
// The default sizes live here so every block in the FFT output path agrees on them.
package fft_out_stream_pkg;

   localparam int FFT_DAT_WD = 16;
   localparam int FFT_GRP    = 8;
   localparam int FFT_N      = FFT_GRP * FFT_GRP;
   localparam int FFT_LOG2N  = $clog2(FFT_N);

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_t;

   // A bank may take group writes only until it is complete.
   function automatic logic bank_open(input bank_state_t s);
      return (s == BANK_EMPTY) || (s == BANK_FILLING);
   endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One ping-pong bank: a whole group is written per cycle, one complex word read per cycle.
// Storage is split into GRP columns so each column is a plain one-write/one-read RAM.
module fft_pp_bank
   import fft_out_stream_pkg::*;
#(
   parameter int DAT_WD = FFT_DAT_WD,
   parameter int GRP    = FFT_GRP,
   parameter int N      = FFT_N
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [$clog2(GRP)-1:0]    wr_grp,
   input  logic [GRP*2*DAT_WD-1:0]   wr_dat,
   input  logic                      rd_en,
   input  logic [$clog2(N)-1:0]      rd_addr,
   output logic [2*DAT_WD-1:0]       rd_dat
);

   localparam int GW = $clog2(GRP);
   localparam int AW = $clog2(N);
   localparam int CW = 2 * DAT_WD;

   logic [CW-1:0] col_rd [GRP];
   logic [GW-1:0] col_sel_reg;

   // Column k holds bin g*GRP+k at row g; the bin's row is the upper index bits.
   genvar gi;
   generate
      for (gi = 0; gi < GRP; gi++) begin : g_col
         logic [CW-1:0] mem [GRP];
         logic [CW-1:0] rd_reg;

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[wr_grp] <= wr_dat[gi*CW +: CW];
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               rd_reg <= '0;
            end else if (rd_en) begin
               rd_reg <= mem[rd_addr[AW-1:GW]];
            end
         end

         assign col_rd[gi] = rd_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_sel_reg <= '0;
      end else if (rd_en) begin
         col_sel_reg <= rd_addr[GW-1:0];
      end
   end

   assign rd_dat = col_rd[col_sel_reg];

endmodule

// File: rtl/fft_out_stream.sv
// Reorders FFT results arriving as groups of GRP bins into a bin-ordered sample stream
// through two ping-pong banks; one bank fills while the other drains.
module fft_out_stream
   import fft_out_stream_pkg::*;
#(
   parameter int DAT_WD = FFT_DAT_WD,
   parameter int GRP    = FFT_GRP,
   parameter int N      = FFT_N
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      val_i,
   output logic                      rdy_o,
   input  logic [$clog2(GRP)-1:0]    grp_i,
   input  logic [GRP*2*DAT_WD-1:0]   dat_i,
   output logic                      val_o,
   input  logic                      rdy_i,
   output logic [DAT_WD-1:0]         dat_re_o,
   output logic [DAT_WD-1:0]         dat_im_o,
   output logic [$clog2(N)-1:0]      idx_o,
   output logic                      sop_o,
   output logic                      eop_o,
   output logic                      err_o
);

   localparam int AW = $clog2(N);
   localparam int CW = 2 * DAT_WD;
   localparam logic [AW-1:0]  IDX_LAST  = AW'(N - 1);
   localparam logic [GRP-1:0] MASK_FULL = '1;

   bank_state_t    state_reg [2];
   bank_state_t    state_next [2];
   logic           wb_reg, wb_next;
   logic           rb_reg, rb_next;
   logic [GRP-1:0] mask_reg, mask_next;
   logic           val_reg, val_next;
   logic [AW-1:0]  idx_reg, idx_next;
   logic           err_reg, err_next;

   logic           wr_fire;
   logic           rd_fire;
   logic           rd_adv;
   logic           dup;
   logic [GRP-1:0] mask_set;
   logic [CW-1:0]  bank_rd [2];

   assign rdy_o   = bank_open(state_reg[wb_reg]);
   assign wr_fire = val_i && rdy_o;
   assign rd_fire = val_reg && rdy_i;
   assign rd_adv  = !val_reg || rd_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg[0] <= BANK_EMPTY;
         state_reg[1] <= BANK_EMPTY;
         wb_reg       <= 1'b0;
         rb_reg       <= 1'b0;
         mask_reg     <= '0;
         val_reg      <= 1'b0;
         idx_reg      <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         wb_reg    <= wb_next;
         rb_reg    <= rb_next;
         mask_reg  <= mask_next;
         val_reg   <= val_next;
         idx_reg   <= idx_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      wb_next    = wb_reg;
      rb_next    = rb_reg;
      mask_next  = mask_reg;
      val_next   = val_reg;
      idx_next   = idx_reg;
      err_next   = 1'b0;
      dup        = 1'b0;
      mask_set   = mask_reg;

      // Fill side: a repeated group overwrites its data but can never complete the frame.
      if (wr_fire) begin
         dup      = mask_reg[grp_i];
         mask_set = mask_reg | (GRP'(1) << grp_i);
         err_next = dup;
         if (state_reg[wb_reg] == BANK_EMPTY) begin
            state_next[wb_reg] = BANK_FILLING;
         end
         if (!dup && (mask_set == MASK_FULL)) begin
            state_next[wb_reg] = BANK_FULL;
            mask_next          = '0;
            wb_next            = ~wb_reg;
         end else begin
            mask_next = mask_set;
         end
      end

      // Drain side always works on the other bank than an accepted write, so both apply.
      if (rd_fire) begin
         if (idx_reg == IDX_LAST) begin
            state_next[rb_reg] = BANK_EMPTY;
            rb_next            = ~rb_reg;
            idx_next           = '0;
            if (state_reg[~rb_reg] == BANK_FULL) begin
               state_next[~rb_reg] = BANK_DRAINING;
            end else begin
               val_next = 1'b0;
            end
         end else begin
            idx_next = idx_reg + AW'(1);
         end
      end else if (!val_reg && (state_reg[rb_reg] == BANK_FULL)) begin
         state_next[rb_reg] = BANK_DRAINING;
         val_next           = 1'b1;
         idx_next           = '0;
      end
   end

   // The read is issued with the next index so data lands together with idx_o.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         fft_pp_bank #(
            .DAT_WD (DAT_WD),
            .GRP    (GRP),
            .N      (N)
         ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_fire && (wb_reg == 1'(gi))),
            .wr_grp  (grp_i),
            .wr_dat  (dat_i),
            .rd_en   (rd_adv && val_next && (rb_next == 1'(gi))),
            .rd_addr (idx_next),
            .rd_dat  (bank_rd[gi])
         );
      end
   endgenerate

   assign val_o    = val_reg;
   assign idx_o    = idx_reg;
   assign dat_re_o = bank_rd[rb_reg][CW-1:DAT_WD];
   assign dat_im_o = bank_rd[rb_reg][DAT_WD-1:0];
   assign sop_o    = val_reg && (idx_reg == '0);
   assign eop_o    = val_reg && (idx_reg == IDX_LAST);
   assign err_o    = err_reg;

endmodule

// File: tb/tb_fft_out_stream.sv
// Scoreboard bench for fft_out_stream: completed frames queue their 64 expected samples,
// and every valid output cycle is compared against the head of that queue.
module tb_fft_out_stream;

   localparam int DW  = 16;
   localparam int GRP = 8;
   localparam int N   = 64;
   localparam int CW  = 2 * DW;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               val_i = 1'b0;
   logic               rdy_o;
   logic [2:0]         grp_i = '0;
   logic [GRP*CW-1:0]  dat_i = '0;
   logic               val_o;
   logic               rdy_i = 1'b0;
   logic [DW-1:0]      dat_re_o;
   logic [DW-1:0]      dat_im_o;
   logic [5:0]         idx_o;
   logic               sop_o;
   logic               eop_o;
   logic               err_o;

   typedef struct {
      int idx;
      int re;
      int im;
   } smp_t;

   smp_t       exp_q [$];
   smp_t       mon_e;
   int         n_chk = 0;
   int         n_pass = 0;
   int         st_re [N];
   int         st_im [N];
   logic [7:0] st_mask = '0;
   int         err_cnt = 0;
   int         xfer_cnt = 0;
   bit         mon_en = 1'b0;
   bit         rdy_mode = 1'b0;
   bit         rdy_fix = 1'b0;

   always #5 clk = ~clk;

   fft_out_stream dut (
      .clk      (clk),
      .rst      (rst),
      .val_i    (val_i),
      .rdy_o    (rdy_o),
      .grp_i    (grp_i),
      .dat_i    (dat_i),
      .val_o    (val_o),
      .rdy_i    (rdy_i),
      .dat_re_o (dat_re_o),
      .dat_im_o (dat_im_o),
      .idx_o    (idx_o),
      .sop_o    (sop_o),
      .eop_o    (eop_o),
      .err_o    (err_o)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Downstream ready: fixed level or a fair coin, changed just after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rdy_i = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fix;
      end
   end

   // Output monitor: compares every valid cycle (stalled or not) with the queue head.
   always @(negedge clk) begin
      if (rst && mon_en) begin
         if (err_o) err_cnt++;
         if (val_o) begin
            if (exp_q.size() == 0) begin
               check("spurious_val", 1, 0);
            end else begin
               mon_e = exp_q[0];
               check("idx", int'(idx_o), mon_e.idx);
               check("re", int'($signed(dat_re_o)), mon_e.re);
               check("im", int'($signed(dat_im_o)), mon_e.im);
               check("sop", int'(sop_o), int'(mon_e.idx == 0));
               check("eop", int'(eop_o), int'(mon_e.idx == N - 1));
               if (rdy_i) begin
                  void'(exp_q.pop_front());
                  xfer_cnt++;
               end
            end
         end
      end
   end

   // Offer one group (bin b carries re=b+bias, im=-b) and update the frame model on acceptance.
   task automatic write_grp(input int g, input int bias);
      int n;
      @(negedge clk);
      val_i = 1'b1;
      grp_i = 3'(g);
      for (int k = 0; k < GRP; k++) begin
         dat_i[k*CW +: CW] = {DW'(g*GRP + k + bias), DW'(-(g*GRP + k))};
      end
      n = 0;
      while (!rdy_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         check("wr_timeout", 0, 1);
         val_i = 1'b0;
         return;
      end
      @(posedge clk);
      #1 val_i = 1'b0;
      $display("wr grp=%0d bias=%0d t=%0t", g, bias, $time);
      for (int k = 0; k < GRP; k++) begin
         st_re[g*GRP + k] = g*GRP + k + bias;
         st_im[g*GRP + k] = -(g*GRP + k);
      end
      st_mask = st_mask | 8'(1 << g);
      if (st_mask == 8'hFF) begin
         for (int b = 0; b < N; b++) begin
            exp_q.push_back('{idx: b, re: st_re[b], im: st_im[b]});
         end
         st_mask = '0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || val_o) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   int ord2 [8] = '{7, 3, 0, 5, 1, 6, 2, 4};
   int gap;
   int eop_n;
   int n_wait;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_val", int'(val_o), 0);
      check("rst_rdy", int'(rdy_o), 1);
      check("rst_idx", int'(idx_o), 0);
      check("rst_sop_eop", int'({sop_o, eop_o}), 0);
      check("rst_err", int'(err_o), 0);
      check("rst_dat", int'({dat_re_o, dat_im_o}), 0);
      rst = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      check("rel_rdy", int'(rdy_o), 1);

      // Test 1: in-order groups, latency one cycle after the last write
      rdy_fix = 1'b1;
      @(negedge clk);
      for (int g = 0; g < GRP; g++) write_grp(g, 0);
      @(negedge clk);
      check("t1_lat_early", int'(val_o), 0);
      @(negedge clk);
      check("t1_lat_val", int'(val_o), 1);
      check("t1_lat_idx", int'(idx_o), 0);
      wait_drain();
      check("t1_err", err_cnt, 0);

      // Test 2: scrambled group order
      for (int i = 0; i < GRP; i++) write_grp(ord2[i], 0);
      @(negedge clk);
      check("t2_lat_early", int'(val_o), 0);
      @(negedge clk);
      check("t2_lat_val", int'(val_o), 1);
      wait_drain();

      // Test 3: both banks full, then a gapless 128-sample drain
      rdy_fix = 1'b0;
      repeat (2) @(negedge clk);
      for (int g = 0; g < GRP; g++) write_grp(g, 1000);
      for (int g = GRP - 1; g >= 0; g--) write_grp(g, 2000);
      @(negedge clk);
      check("t3_rdy_both_full", int'(rdy_o), 0);
      xfer_cnt = 0;
      gap = 0;
      eop_n = 0;
      rdy_fix = 1'b1;
      for (int n = 0; n < 400 && xfer_cnt < 128; n++) begin
         @(negedge clk);
         if (eop_n == 1) begin
            check("t3_rdy_rise", int'(rdy_o), 1);
            eop_n = 2;
         end
         if (!val_o && xfer_cnt < 128) gap++;
         if (val_o && rdy_i && eop_o && eop_n == 0) begin
            check("t3_rdy_at_eop", int'(rdy_o), 0);
            eop_n = 1;
         end
      end
      check("t3_gap", gap, 0);
      check("t3_xfers", xfer_cnt, 128);
      check("t3_eop_seen", eop_n, 2);
      wait_drain();

      // Test 4: random downstream stalls over two frames
      rdy_mode = 1'b1;
      for (int g = 0; g < GRP; g++) write_grp(g, 3000);
      for (int i = 0; i < GRP; i++) write_grp(ord2[i], 4000);
      wait_drain();
      rdy_mode = 1'b0;
      rdy_fix = 1'b1;
      @(negedge clk);

      // Test 5: duplicate write of group 2
      err_cnt = 0;
      for (int g = 0; g < 3; g++) write_grp(g, 0);
      write_grp(2, 100);
      for (int g = 3; g < GRP; g++) write_grp(g, 0);
      wait_drain();
      check("t5_err_pulses", err_cnt, 1);

      // Test 6: reset mid-drain with the other bank full
      for (int g = 0; g < GRP; g++) write_grp(g, 5000);
      for (int g = 0; g < GRP; g++) write_grp(g, 6000);
      n_wait = 0;
      while (!(val_o && idx_o == 6'd30) && n_wait < 500) begin
         @(negedge clk);
         n_wait++;
      end
      check("t6_reach_idx30", int'(val_o && idx_o == 6'd30), 1);
      check("t6_both_busy", int'(rdy_o), 0);
      rst = 1'b0;
      #1;
      check("t6_rst_val", int'(val_o), 0);
      exp_q.delete();
      st_mask = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t6_no_val", int'(val_o), 0);
         check("t6_rdy", int'(rdy_o), 1);
      end
      for (int g = 0; g < GRP; g++) write_grp(g, 7000);
      @(negedge clk);
      @(negedge clk);
      check("t6_next_val", int'(val_o), 1);
      wait_drain();
      check("t6_idle", int'(val_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
